jtag_shift_master: RTL
======================

JTAG_SHIFT_MASTER -- requirements
Module: jtag_shift_master

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, giving the maximum shift length in bits.
REQ-002 SHALL have port TCK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port TRST_N  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled on TCK rising edge.
REQ-005 SHALL have port is_ir  input  1  1 = IR scan, 0 = DR scan; latched with start.
REQ-006 SHALL have port len  input  6  shift length in bits; latched with start.
REQ-007 SHALL have port data_in  input  MAX_LEN  shift data, LSB shifted first; latched with start.
REQ-008 SHALL have port TDO  input  1  serial return from the downstream TAP.
REQ-009 SHALL have port TMS  output  1  registered TAP mode select to the downstream TAP.
REQ-010 SHALL have port TDI  output  1  registered serial data to the downstream TAP.
REQ-011 SHALL have port busy  output  1  high while a reset sequence or a scan is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at scan completion.
REQ-013 SHALL have port data_out  output  MAX_LEN  captured TDO bits; bit k is the k-th bit shifted.

Function
REQ-014 SHALL implement states RSTSEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE; TMS and TDI are registered and driven as a function of state.
REQ-015 SHALL accept start only when in IDLE with busy=0; start is ignored in all other states, and the latched operands are not disturbed.
REQ-016 SHALL, on acceptance, latch is_ir, len, and data_in, and drive busy=1 from the next cycle onward.
REQ-017 SHALL treat len=0 as 1 and len>MAX_LEN as MAX_LEN.
REQ-018 SHALL, for a DR scan, drive TMS per cycle starting the cycle after acceptance as: 1 (SEL_DR), 0 (CAPTURE), 0 (first SHIFT entry), then the shift cycles.
REQ-019 SHALL, for an IR scan, drive TMS as: 1 (SEL_DR), 1 (SEL_IR), 0 (CAPTURE), 0, then the shift cycles.
REQ-020 SHALL run len shift cycles k=0..len-1 with TDI=data[k]; TMS=0 for k<len-1 and TMS=1 for k=len-1.
REQ-021 SHALL follow the shift cycles with TMS=1 (EXIT1->UPDATE), then TMS=0 (return to IDLE); done=1 and busy=0 during that final cycle.
REQ-022 SHALL give a total scan length of len+5 cycles for DR and len+6 cycles for IR, measured from the first TMS cycle to the done cycle inclusive.
REQ-023 SHALL drive TDI=0 in every non-shift cycle.
REQ-024 SHALL set data_out[k] to the TDO value sampled on the rising edge that ends shift cycle k.
REQ-025 SHALL clear data_out bits >= len at acceptance and leave them zero.
REQ-026 SHALL hold data_out stable from done until the next accepted start.
REQ-027 SHALL accept a start asserted in the done cycle; the next scan's first TMS=1 then immediately follows the TMS=0 of that done cycle.

Reset
REQ-028 SHALL, while TRST_N=0 at a rising edge, force TMS=1, TDI=0, busy=1, done=0, data_out=0, and state RSTSEQ.
REQ-029 SHALL, after TRST_N returns high, drive TMS=1 for 5 cycles, then TMS=0 and enter IDLE with busy=0 in that same cycle.
REQ-030 SHALL abort any scan in progress on reset, with no done pulse and no partial data_out.

Verification
REQ-031 SHALL cover post-reset: release TRST_N -> TMS=1,1,1,1,1,0; busy falls on the 6th cycle.
REQ-032 SHALL cover DR scan, len=8, data_in=0xA5 -> TMS=1,0,0,0,0,0,0,0,0,0,1,1,0 (13 cycles); TDI in shift cycles = 1,0,1,0,0,1,0,1; done on the 13th cycle.
REQ-033 SHALL cover IR scan, len=5, data_in=0x00 -> TMS=1,1,0,0,0,0,0,0,1,1,0 (11 cycles); TDI=0 throughout.
REQ-034 SHALL cover loopback with TDO tied to TDI, DR len=8, data_in=0xA5 -> data_out=0x000000A5 at done.
REQ-035 SHALL cover start pulsed mid-scan and len=0 -> the mid-scan start is ignored (TMS sequence unchanged), and len=0 produces exactly 1 shift cycle.
REQ-036 SHALL cover TRST_N=0 during SHIFT -> next cycle TMS=1, busy=1, data_out=0, done never pulses.

Source files
------------

// File: rtl/jtag_shift_master.sv
// JTAG scan master: walks a downstream TAP through a TMS reset sequence,
// then runs DR or IR shift scans on request and captures the returned TDO bits.
module jtag_shift_master #(
    parameter int unsigned MAX_LEN = 32
) (
    input  logic               TCK,
    input  logic               TRST_N,
    input  logic               start,
    input  logic               is_ir,
    input  logic [5:0]         len,
    input  logic [MAX_LEN-1:0] data_in,
    input  logic               TDO,
    output logic               TMS,
    output logic               TDI,
    output logic               busy,
    output logic               done,
    output logic [MAX_LEN-1:0] data_out
);

    typedef enum logic [2:0] {
        StRstSeq,
        StIdle,
        StSelDr,
        StSelIr,
        StCapture,
        StShift,
        StExit1,
        StUpdate
    } state_e;

    localparam logic [5:0] LenMax = 6'(MAX_LEN);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               is_ir_q, is_ir_d;
    logic [5:0]         last_q, last_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] dout_q, dout_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic [5:0]         len_eff;
    logic [MAX_LEN-1:0] keep_mask;
    logic [MAX_LEN-1:0] bit_sel;
    logic [MAX_LEN-1:0] data_sh;

    assign TMS      = tms_q;
    assign TDI      = tdi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;

    // A request can only be taken while idle or in the done cycle of the previous scan.
    assign accept = start && !busy_q && (state_q == StIdle || state_q == StUpdate);

    always_comb begin
        len_eff = len;
        if (len == 6'd0) begin
            len_eff = 6'd1;
        end else if (len > LenMax) begin
            len_eff = LenMax;
        end
    end

    assign keep_mask = ~({MAX_LEN{1'b1}} << len_eff);
    assign bit_sel   = {{(MAX_LEN-1){1'b0}}, 1'b1} << cnt_q;

    // Next-state and operand latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_ir_d = is_ir_q;
        last_d  = last_q;
        data_d  = data_q;
        dout_d  = dout_q;

        unique case (state_q)
            StRstSeq: begin
                if (cnt_q == 6'd5) begin
                    state_d = StIdle;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StIdle: begin
                state_d = StIdle;
            end
            StSelDr: begin
                state_d = is_ir_q ? StSelIr : StCapture;
                cnt_d   = 6'd0;
            end
            StSelIr: begin
                state_d = StCapture;
                cnt_d   = 6'd0;
            end
            StCapture: begin
                // Two TMS=0 cycles: into Capture, then into Shift.
                if (cnt_q == 6'd0) begin
                    cnt_d = 6'd1;
                end else begin
                    state_d = StShift;
                    cnt_d   = 6'd0;
                end
            end
            StShift: begin
                dout_d = (dout_q & ~bit_sel) | (TDO ? bit_sel : '0);
                if (cnt_q == last_q) begin
                    state_d = StExit1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StExit1: begin
                state_d = StUpdate;
            end
            StUpdate: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StRstSeq;
                cnt_d   = 6'd0;
            end
        endcase

        if (accept) begin
            state_d = StSelDr;
            cnt_d   = 6'd0;
            is_ir_d = is_ir;
            last_d  = len_eff - 6'd1;
            data_d  = data_in;
            dout_d  = dout_q & keep_mask;
        end
    end

    assign data_sh = data_d >> cnt_d;

    // Registered pin values are decoded from the state being entered.
    always_comb begin
        tms_d  = 1'b0;
        tdi_d  = 1'b0;
        busy_d = 1'b1;
        done_d = 1'b0;
        case (state_d)
            StRstSeq: tms_d = 1'b1;
            StIdle:   busy_d = 1'b0;
            StSelDr:  tms_d = 1'b1;
            StSelIr:  tms_d = 1'b1;
            StShift: begin
                tms_d = (cnt_d == last_d);
                tdi_d = data_sh[0];
            end
            StExit1:  tms_d = 1'b1;
            StUpdate: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                tms_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            state_q <= StRstSeq;
            cnt_q   <= 6'd0;
            is_ir_q <= 1'b0;
            last_q  <= 6'd0;
            data_q  <= '0;
            dout_q  <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_ir_q <= is_ir_d;
            last_q  <= last_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
